aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller: accepts a 128-bit cipher key over a valid/ready handshake and expands it into round keys 0..10, one per cycle, using a single shared round-expansion step. It stores all 11 round keys in an internal register file and serves them to the cipher core over a registered read port. Reads may start while expansion is still running; a per-read hit flag tells the requester whether the requested round key is already valid.

## Interface
- NR, 10, number of rounds; fixed for AES-128, sets 11 register-file entries.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  controller can accept a key; high in IDLE and DONE.
- key_in  in  128  cipher key; word 0 is bits [127:96].
- rd_req  in  1  round-key read request.
- rd_idx  in  4  round-key index, 0..10.
- rd_valid  out  1  read response valid, one cycle after rd_req.
- rd_hit  out  1  requested entry was valid when sampled.
- rd_data  out  128  round key; 0 when not hit.
- valid_cnt  out  4  number of valid entries, 0..11.
- done  out  1  all 11 round keys valid.
- zeroize  in  1  only with AES_KSCHED_ZEROIZE_EN; clears key material.

## Operation
- FSM states: IDLE, EXPAND, DONE (plus ZERO under the macro).
- IDLE → EXPAND on key_valid & key_ready; on that edge rk[0]←key_in, cnt←0, valid_cnt←1.
- EXPAND, each cycle: rk[cnt+1]←round(rk[cnt], RCON[cnt]); cnt←cnt+1; valid_cnt←valid_cnt+1.
- EXPAND → DONE on the edge that writes rk[10] (cnt==9).
- round(): temp = SubWord(RotWord(w3)) ^ {RCON,24'h0}; w0'=w0^temp; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- RCON sequence: 01,02,04,08,10,20,40,80,1b,36.
- DONE: a new handshake restarts the expansion exactly as from IDLE. valid_cnt drops to 1, done clears, and the old entries 1..10 are treated as invalid.
- key_ready is low in EXPAND; key_valid in EXPAND is ignored, not queued.
- Read hit: hit = (rd_idx < valid_cnt), both sampled in the same cycle.
  - On hit: rd_data = rk[rd_idx].
  - On miss, or rd_idx > 10: rd_hit=0, rd_data=0.
- A read coincident with a load or entry write sees the pre-edge contents and valid_cnt.
- Reset mid-expansion aborts immediately: state IDLE, cnt 0, valid_cnt 0, all entries cleared.

## Timing
- Reset values: key_ready=1, rd_valid=0, rd_hit=0, rd_data=0, valid_cnt=0, done=0, state IDLE, register file all zero.
- Key accepted at edge T:
  - entry k is written at edge T+k, so it is readable with hit from cycle T+k+1;
  - done=1 and key_ready=1 from cycle T+11;
  - minimum load-to-load interval is 11 cycles.
- Read latency is exactly 1 cycle.
  - rd_valid is a registered copy of rd_req; no backpressure.
  - Back-to-back reads are sustained every cycle.
- done and valid_cnt are registered outputs.

## Configuration
- AES_KSCHED_ZEROIZE_EN defined: the zeroize port exists.
  - zeroize=1 in any state enters ZERO; the next edge clears all 11 entries, valid_cnt, cnt and done, then the FSM goes to IDLE.
  - key_ready is low in ZERO.
  - zeroize has priority over a simultaneous key handshake.
- Not defined: no port, no ZERO state. Entries persist until overwritten or reset.

## Structure
- Package aes_pkg holds:
  - NR=10 and NK_WORDS=4;
  - the RCON table as a 10×8-bit constant array;
  - the FSM state enum;
  - the round-key typedef (128-bit).
- Sub-module aes_key_round: combinational single expansion step (prev key, rcon → next key), instantiating the existing sbox four times. The controller holds one instance, driven by rk[cnt] and RCON[cnt].

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted at T → at T+12 read idx 1 returns hit, a0fafe1788542cb123a339392a6c7605; idx 10 returns d014f9a8c9ee2589e13f0cc8b6630ca6; done=1 from T+11.
- Same key, read idx 3 every cycle from T+1 → rd_hit=0, rd_data=0 through the response for the cycle T+3 read. The first hit responds in cycle T+5 (read sampled in T+4) with 3d80477d4716fe3e1e237e446d7a883b.
- Reads of idx 11 and 15 in DONE → rd_valid=1, rd_hit=0, rd_data=0.
- key_valid held in EXPAND with a different key → ignored, key_ready=0, and the final keys match the first key. A new key accepted in DONE → valid_cnt=1 on the next cycle, and the old idx 5 read misses.
- rst_n asserted at T+4 → all outputs at reset values immediately. After release, an idx 0 read misses until a new load.
- With AES_KSCHED_ZEROIZE_EN: zeroize in DONE, coincident with key_valid → key not accepted, valid_cnt=0, idx 0 read returns 0, FSM back in IDLE two cycles later with key_ready=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants, types and GF(2^8) arithmetic for the AES-128 key-schedule controller.
package aes_pkg;

    localparam int NR       = 10;
    localparam int NK_WORDS = 4;
    localparam int NUM_RK   = NR + 1;

    typedef logic [127:0] rk_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2,
        ST_ZERO   = 2'd3
    } ks_state_e;

    // Round constants, indexed by the expansion step (0..9).
    localparam logic [7:0] RCON [NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiplication in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: previous round key plus RCON gives the next round key.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w, sub_w, temp_w;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w = {w3[23:0], w3[31:24]};

    // Four S-boxes cover the rotated last word byte by byte.
    for (genvar gi = 0; gi < NK_WORDS; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w[gi*8 +: 8]),
            .out_byte (sub_w[gi*8 +: 8])
        );
    end

    assign temp_w   = sub_w ^ {rcon, 24'h0};
    assign n0       = w0 ^ temp_w;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES S-box: multiplicative inverse in GF(2^8) (0 maps to 0) followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] inv;

    // Inverse as x^254 = product of x^(2^k) for k = 1..7, then the affine map.
    always_comb begin
        logic [7:0] sq;
        sq  = in_byte;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller with an 11-entry round-key register file
// and a registered read port. Optional build macro: AES_KSCHED_ZEROIZE_EN adds the
// zeroize input and a ZERO state that wipes all key material.
module aes_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic         rd_req,
    input  logic [3:0]   rd_idx,
    output logic         rd_valid,
    output logic         rd_hit,
    output logic [127:0] rd_data,
    output logic [3:0]   valid_cnt,
    output logic         done
`ifdef AES_KSCHED_ZEROIZE_EN
    ,
    input  logic         zeroize
`endif
);

    ks_state_e    state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [3:0]   valid_cnt_q, valid_cnt_d;
    logic         done_q, done_d;
    logic         key_ready_q, key_ready_d;
    rk_t          rk_q [NUM_RK];
    rk_t          rk_d [NUM_RK];
    logic         rd_valid_q;
    logic         rd_hit_q, rd_hit_d;
    rk_t          rd_data_q, rd_data_d;
    rk_t          round_key;

    // Single shared expansion step, always fed from the most recently written entry.
    aes_key_round u_round (
        .prev_key (rk_q[cnt_q]),
        .rcon     (RCON[cnt_q]),
        .next_key (round_key)
    );

    // Next-state, counters and register-file writes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_cnt_d = valid_cnt_q;
        rk_d        = rk_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (key_valid && key_ready_q) begin
                    state_d     = ST_EXPAND;
                    cnt_d       = 4'd0;
                    valid_cnt_d = 4'd1;
                    rk_d[0]     = key_in;
                end
            end
            ST_EXPAND: begin
                rk_d[cnt_q + 4'd1] = round_key;
                cnt_d              = cnt_q + 4'd1;
                valid_cnt_d        = valid_cnt_q + 4'd1;
                if (cnt_q == 4'd9) state_d = ST_DONE;
            end
`ifdef AES_KSCHED_ZEROIZE_EN
            ST_ZERO: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef AES_KSCHED_ZEROIZE_EN
        // Zeroize wins over any handshake; material stays cleared while in ZERO.
        if (zeroize || state_q == ST_ZERO) begin
            if (zeroize) state_d = ST_ZERO;
            cnt_d       = 4'd0;
            valid_cnt_d = 4'd0;
            for (int i = 0; i < NUM_RK; i++) rk_d[i] = '0;
        end
`endif
        done_d      = (state_d == ST_DONE);
        key_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // Read port: hit decided against the pre-edge valid count, data forced to 0 on a miss.
    always_comb begin
        rd_hit_d  = rd_req && (rd_idx < valid_cnt_q);
        rd_data_d = '0;
        if (rd_hit_d) rd_data_d = rk_q[rd_idx];
    end

    // Control and read-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            valid_cnt_q <= 4'd0;
            done_q      <= 1'b0;
            key_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_hit_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_cnt_q <= valid_cnt_d;
            done_q      <= done_d;
            key_ready_q <= key_ready_d;
            rd_valid_q  <= rd_req;
            rd_hit_q    <= rd_hit_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Round-key register file, one register per entry.
    for (genvar gi = 0; gi < NUM_RK; gi++) begin : g_rk
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rk_q[gi] <= '0;
            else        rk_q[gi] <= rk_d[gi];
        end
    end

    assign key_ready = key_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_hit    = rd_hit_q;
    assign rd_data   = rd_data_q;
    assign valid_cnt = valid_cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: directed FIPS-197 vectors plus randomized
// traffic against a word-level key-expansion model and a valid-count tracker.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rd_req;
    logic [3:0]   rd_idx;
    logic         rd_valid;
    logic         rd_hit;
    logic [127:0] rd_data;
    logic [3:0]   valid_cnt;
    logic         done;
`ifdef AES_KSCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rd_req    (rd_req),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .valid_cnt (valid_cnt),
        .done      (done)
`ifdef AES_KSCHED_ZEROIZE_EN
        ,
        .zeroize   (zeroize)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]   sbox_tbl [256];
    logic [127:0] ref_keys [11];
    int           ref_vc;
    bit           ref_zero;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d = {v, v};
        return d[15-n -: 8];
    endfunction

    // S-box built by exhaustive search for each inverse.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard 44-word AES-128 expansion.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ref_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One clock edge: predict the read response and new status from pre-edge inputs, then compare.
    task automatic tick();
        bit           ready;
        bit           zin;
        logic         exp_hit;
        logic         exp_valid;
        logic [127:0] exp_data;
        ready     = !ref_zero && (ref_vc == 0 || ref_vc == 11);
        exp_valid = rd_req;
        exp_hit   = rd_req && (int'(rd_idx) < ref_vc);
        exp_data  = exp_hit ? ref_keys[rd_idx] : 128'h0;
        zin       = 1'b0;
`ifdef AES_KSCHED_ZEROIZE_EN
        zin       = zeroize;
`endif
        if (zin) begin
            ref_vc   = 0;
            ref_zero = 1'b1;
        end else if (ref_zero) begin
            ref_zero = 1'b0;
        end else if (key_valid && ready) begin
            ref_vc = 1;
            expand(key_in);
        end else if (ref_vc >= 1 && ref_vc <= 10) begin
            ref_vc++;
        end
        @(posedge clk);
        #1;
        check_eq("rd_valid",  128'(rd_valid),  128'(exp_valid));
        check_eq("rd_hit",    128'(rd_hit),    128'(exp_hit));
        check_eq("rd_data",   rd_data,         exp_data);
        check_eq("valid_cnt", 128'(valid_cnt), 128'(ref_vc));
        check_eq("done",      128'(done),      128'(ref_vc == 11));
        check_eq("key_ready", 128'(key_ready), 128'(!ref_zero && (ref_vc == 0 || ref_vc == 11)));
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_eq("rst_key_ready", 128'(key_ready), 128'(1));
        check_eq("rst_rd_valid",  128'(rd_valid),  128'(0));
        check_eq("rst_rd_hit",    128'(rd_hit),    128'(0));
        check_eq("rst_rd_data",   rd_data,         128'h0);
        check_eq("rst_valid_cnt", 128'(valid_cnt), 128'(0));
        check_eq("rst_done",      128'(done),      128'(0));
        ref_vc    = 0;
        ref_zero  = 1'b0;
        key_valid = 1'b0;
        rd_req    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        build_sbox();
        for (int r = 0; r < 11; r++) ref_keys[r] = '0;
        ref_vc    = 0;
        ref_zero  = 1'b0;
        rst_n     = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rd_req    = 1'b0;
        rd_idx    = '0;
`ifdef AES_KSCHED_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        #1;
        do_reset();
        tick();

        // FIPS-197 key, then poll idx 3 every cycle while expansion runs.
        key_in = FIPS_KEY; key_valid = 1'b1;
        tick();
        key_valid = 1'b0; rd_req = 1'b1; rd_idx = 4'd3;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 3) check_eq("idx3_miss_t3", 128'(rd_hit), 128'(0));
            if (k == 4) check_eq("fips_rk3_first", rd_data, 128'h3d80477d4716fe3e1e237e446d7a883b);
        end
        check_eq("fips_done", 128'(done), 128'(1));
        rd_idx = 4'd1;  tick(); check_eq("fips_rk1",  rd_data, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; tick(); check_eq("fips_rk10", rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd11; tick();
        rd_idx = 4'd15; tick();
        rd_req = 1'b0;

        // Key offered throughout expansion must be ignored.
        key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1;
        tick();
        key_in = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 9; k++) tick();
        key_valid = 1'b0;
        tick();
        rd_req = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i);
            tick();
        end

        // Reload in DONE: old entry 5 no longer counts.
        key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1; rd_req = 1'b0;
        tick();
        key_valid = 1'b0; rd_req = 1'b1; rd_idx = 4'd5;
        tick();
        check_eq("reload_idx5_miss", 128'(rd_hit), 128'(0));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            key_valid = ($urandom_range(0, 15) == 0);
            key_in    = {$urandom, $urandom, $urandom, $urandom};
            rd_req    = ($urandom_range(0, 3) != 0);
            rd_idx    = 4'($urandom_range(0, 15));
            tick();
        end
        key_valid = 1'b0;
        for (int k = 0; k < 12; k++) tick();

        // Reset in the middle of an expansion.
        key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1; rd_req = 1'b0;
        tick();
        key_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        do_reset();
        rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        check_eq("post_rst_idx0_miss", 128'(rd_hit), 128'(0));
        tick();

`ifdef AES_KSCHED_ZEROIZE_EN
        // Zeroize in DONE with a coincident handshake.
        key_in = {$urandom, $urandom, $urandom, $urandom}; key_valid = 1'b1; rd_req = 1'b0;
        tick();
        key_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        zeroize = 1'b1; key_valid = 1'b1;
        tick();
        zeroize = 1'b0; key_valid = 1'b0; rd_req = 1'b1; rd_idx = 4'd0;
        tick();
        check_eq("zero_idx0_data", rd_data, 128'h0);
        check_eq("zero_ready_back", 128'(key_ready), 128'(1));
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
